// File: rtl/axi_pkg.sv
// Shared AXI4 field types, encodings and FSM state types used by the SRAM slave and its bus interface.
package axi_pkg;

    localparam int AXI_ID_W = 4;

    typedef logic [AXI_ID_W-1:0] axi_id_t;
    typedef logic [7:0]          axi_len_t;
    typedef logic [2:0]          axi_size_t;
    typedef logic [1:0]          axi_burst_t;
    typedef logic [1:0]          axi_resp_t;

    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
    localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    // WRAP and the reserved encoding are not served by this slave.
    function automatic logic burst_supported(input axi_burst_t burst);
        return (burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR);
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bus bundle (AR/R/AW/W/B) with master and slave views.
interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import axi_pkg::*;

    localparam int STRB_W = DATA_W / 8;

    logic              ar_valid;
    logic              ar_ready;
    axi_id_t           ar_id;
    logic [ADDR_W-1:0] ar_addr;
    axi_len_t          ar_len;
    axi_size_t         ar_size;
    axi_burst_t        ar_burst;

    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    axi_resp_t         r_resp;
    axi_id_t           r_id;
    logic              r_last;

    logic              aw_valid;
    logic              aw_ready;
    axi_id_t           aw_id;
    logic [ADDR_W-1:0] aw_addr;
    axi_len_t          aw_len;
    axi_size_t         aw_size;
    axi_burst_t        aw_burst;

    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_last;

    logic              b_valid;
    logic              b_ready;
    axi_resp_t         b_resp;
    axi_id_t           b_id;

    modport Slave (
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_data, r_resp, r_id, r_last,
        input  r_ready,
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp, b_id,
        input  b_ready
    );

    modport Master (
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_id, r_last,
        output r_ready,
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp, b_id,
        output b_ready
    );

endinterface

// File: rtl/sram_bank.sv
// Word-organised SRAM array: one asynchronous read port and one byte-strobed synchronous write port.
module sram_bank #(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 4096
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr,
    output logic [DATA_W-1:0]            rdata
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // The read is combinational, so a same-edge write is seen only on later cycles.
    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave fronting a byte-strobed SRAM; independent read and write FSMs, FIXED/INCR bursts,
// programmable read latency, SLVERR for unsupported bursts or any out-of-window beat.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                MEM_WORDS = 4096,
    parameter int                RD_LAT    = 1
) (
    input logic  clk,
    input logic  rst_n,
    axi_if.Slave s
);

    localparam int                STRB_W    = DATA_W / 8;
    localparam int                OFF_W     = $clog2(STRB_W);
    localparam int                IDX_W     = $clog2(MEM_WORDS);
    localparam int                EXT_W     = ADDR_W + 16;
    localparam logic [EXT_W-1:0]  MEM_BYTES = EXT_W'(MEM_WORDS * STRB_W);
    localparam axi_size_t         MAX_SIZE  = axi_size_t'(OFF_W);
    localparam int                LAT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(RD_LAT - 1);

    // The whole burst is judged up front: checking the last beat address covers every beat.
    function automatic logic burst_ok(input logic [ADDR_W-1:0] addr, input axi_len_t len,
                                      input axi_size_t size, input axi_burst_t burst);
        logic [EXT_W-1:0] first_off;
        logic [EXT_W-1:0] last_off;
        first_off = EXT_W'(addr) - EXT_W'(BASE_ADDR);
        last_off  = (burst == AXI_BURST_INCR) ? first_off + (EXT_W'(len) << size) : first_off;
        return burst_supported(burst) && (size <= MAX_SIZE) &&
               (addr >= BASE_ADDR) && (last_off < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> OFF_W);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input axi_size_t size, input axi_burst_t burst);
        return (burst == AXI_BURST_INCR) ? addr + (ADDR_W'(1) << size) : addr;
    endfunction

    logic [DATA_W-1:0] mem_rdata;

    rd_state_e         rd_state, rd_state_d;
    axi_id_t           rd_id;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
    axi_len_t          rd_len;
    axi_size_t         rd_size;
    axi_burst_t        rd_burst;
    logic              rd_err;
    axi_len_t          rd_beat, rd_beat_d;
    logic [LAT_W-1:0]  rd_lat, rd_lat_d;
    logic              rd_latch, rd_adv;

    logic              ar_ready_q, ar_ready_d;
    logic              r_valid_q, r_valid_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    axi_resp_t         r_resp_q, r_resp_d;
    axi_id_t           r_id_q, r_id_d;
    logic              r_last_q, r_last_d;

    wr_state_e         wr_state, wr_state_d;
    axi_id_t           wr_id;
    logic [ADDR_W-1:0] wr_addr;
    axi_len_t          wr_len;
    axi_size_t         wr_size;
    axi_burst_t        wr_burst;
    logic              wr_err;
    logic              wr_proto;
    axi_len_t          wr_beat, wr_beat_d;
    logic              aw_hs, wr_hs, wr_last_beat, wr_mis;

    logic              aw_ready_q, aw_ready_d;
    logic              w_ready_q, w_ready_d;
    logic              b_valid_q, b_valid_d;
    axi_resp_t         b_resp_q, b_resp_d;
    axi_id_t           b_id_q, b_id_d;

    assign s.ar_ready = ar_ready_q;
    assign s.r_valid  = r_valid_q;
    assign s.r_data   = r_data_q;
    assign s.r_resp   = r_resp_q;
    assign s.r_id     = r_id_q;
    assign s.r_last   = r_last_q;
    assign s.aw_ready = aw_ready_q;
    assign s.w_ready  = w_ready_q;
    assign s.b_valid  = b_valid_q;
    assign s.b_resp   = b_resp_q;
    assign s.b_id     = b_id_q;

    // ---------------- read channel ----------------
    assign rd_latch    = (rd_state == R_IDLE) && ar_ready_q && s.ar_valid;
    assign rd_adv      = (rd_state == R_DATA) && r_valid_q && s.r_ready && !r_last_q;
    assign rd_addr_nxt = rd_adv ? next_addr(rd_addr, rd_size, rd_burst) : rd_addr;

    always_comb begin
        rd_state_d = rd_state;
        rd_beat_d  = rd_beat;
        rd_lat_d   = rd_lat;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        r_id_d     = r_id_q;
        r_last_d   = r_last_q;
        case (rd_state)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                if (rd_latch) begin
                    ar_ready_d = 1'b0;
                    rd_beat_d  = '0;
                    rd_lat_d   = LAT_INIT;
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_lat == '0) begin
                    rd_state_d = R_DATA;
                    r_valid_d  = 1'b1;
                    r_data_d   = rd_err ? '0 : mem_rdata;
                    r_resp_d   = rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    r_id_d     = rd_id;
                    r_last_d   = (rd_beat == rd_len);
                end else begin
                    rd_lat_d = rd_lat - 1'b1;
                end
            end
            R_DATA: begin
                if (r_valid_q && s.r_ready) begin
                    if (r_last_q) begin
                        rd_state_d = R_IDLE;
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                        ar_ready_d = 1'b1;
                    end else begin
                        // Next beat is fetched through rd_addr_nxt so it appears without a bubble.
                        rd_beat_d = rd_beat + 8'd1;
                        r_data_d  = rd_err ? '0 : mem_rdata;
                        r_last_d  = (rd_beat_d == rd_len);
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state   <= R_IDLE;
            rd_beat    <= '0;
            rd_lat     <= '0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= AXI_RESP_OKAY;
            r_id_q     <= '0;
            r_last_q   <= 1'b0;
        end else begin
            rd_state   <= rd_state_d;
            rd_beat    <= rd_beat_d;
            rd_lat     <= rd_lat_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_id_q     <= r_id_d;
            r_last_q   <= r_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_latch) begin
            rd_id    <= s.ar_id;
            rd_addr  <= s.ar_addr;
            rd_len   <= s.ar_len;
            rd_size  <= s.ar_size;
            rd_burst <= s.ar_burst;
            rd_err   <= !burst_ok(s.ar_addr, s.ar_len, s.ar_size, s.ar_burst);
        end else begin
            rd_addr  <= rd_addr_nxt;
        end
    end

    // ---------------- write channel ----------------
    assign aw_hs        = (wr_state == W_IDLE) && aw_ready_q && s.aw_valid;
    assign wr_hs        = (wr_state == W_DATA) && w_ready_q && s.w_valid;
    assign wr_last_beat = (wr_beat == wr_len);
    assign wr_mis       = (s.w_last != wr_last_beat);

    always_comb begin
        wr_state_d = wr_state;
        wr_beat_d  = wr_beat;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        b_id_d     = b_id_q;
        case (wr_state)
            W_IDLE: begin
                aw_ready_d = 1'b1;
                if (aw_hs) begin
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    wr_beat_d  = '0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wr_hs) begin
                    if (wr_last_beat) begin
                        wr_state_d = W_RESP;
                        w_ready_d  = 1'b0;
                        b_valid_d  = 1'b1;
                        b_id_d     = wr_id;
                        b_resp_d   = (wr_err || wr_proto || wr_mis) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    end else begin
                        wr_beat_d = wr_beat + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (b_valid_q && s.b_ready) begin
                    wr_state_d = W_IDLE;
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state   <= W_IDLE;
            wr_beat    <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= AXI_RESP_OKAY;
            b_id_q     <= '0;
        end else begin
            wr_state   <= wr_state_d;
            wr_beat    <= wr_beat_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            b_id_q     <= b_id_d;
        end
    end

    // A w_last mismatch only taints the response; the address/burst error alone suppresses writes.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            wr_id    <= s.aw_id;
            wr_addr  <= s.aw_addr;
            wr_len   <= s.aw_len;
            wr_size  <= s.aw_size;
            wr_burst <= s.aw_burst;
            wr_err   <= !burst_ok(s.aw_addr, s.aw_len, s.aw_size, s.aw_burst);
            wr_proto <= 1'b0;
        end else if (wr_hs) begin
            wr_addr  <= next_addr(wr_addr, wr_size, wr_burst);
            if (wr_mis) begin
                wr_proto <= 1'b1;
            end
        end
    end

    sram_bank #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_bank (
        .clk   (clk),
        .we    (wr_hs && !wr_err && rst_n),
        .waddr (word_idx(wr_addr)),
        .wdata (s.w_data),
        .wstrb (s.w_strb),
        .raddr (word_idx(rd_addr_nxt)),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single and burst transfers, stalls, strobes, errors, mid-burst reset.
module tb_axi_sram_slave;
    import axi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [1:0]  resp;
    logic [3:0]  bid;
    logic [31:0] exp_beats [4];

    always #5 clk = ~clk;

    axi_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_sram_slave #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .BASE_ADDR (32'h8000_0000),
        .MEM_WORDS (4096),
        .RD_LAT    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] data0, input logic [3:0] strb,
                            input int last_at, output logic [1:0] bresp, output logic [3:0] bidv);
        int n;
        bus.aw_valid = 1'b1;
        bus.aw_addr  = addr;
        bus.aw_id    = id;
        bus.aw_len   = len;
        bus.aw_size  = 3'd2;
        bus.aw_burst = burst;
        n = 0;
        while (bus.aw_ready !== 1'b1 && n < 50) begin tick(); n++; end
        check("aw_ready", 32'(bus.aw_ready), 32'd1);
        tick();
        bus.aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.w_valid = 1'b1;
            bus.w_data  = data0 + 32'(i);
            bus.w_strb  = strb;
            bus.w_last  = (i == last_at);
            n = 0;
            while (bus.w_ready !== 1'b1 && n < 50) begin tick(); n++; end
            check("w_ready", 32'(bus.w_ready), 32'd1);
            tick();
        end
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        bus.b_ready = 1'b1;
        n = 0;
        while (bus.b_valid !== 1'b1 && n < 50) begin tick(); n++; end
        check("b_valid", 32'(bus.b_valid), 32'd1);
        bresp = bus.b_resp;
        bidv  = bus.b_id;
        tick();
        bus.b_ready = 1'b0;
    endtask

    // Returns #1 after the AR handshake edge.
    task automatic rd_start(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst);
        int n;
        bus.ar_valid = 1'b1;
        bus.ar_addr  = addr;
        bus.ar_id    = id;
        bus.ar_len   = len;
        bus.ar_size  = 3'd2;
        bus.ar_burst = burst;
        n = 0;
        while (bus.ar_ready !== 1'b1 && n < 50) begin tick(); n++; end
        check("ar_ready", 32'(bus.ar_ready), 32'd1);
        tick();
        bus.ar_valid = 1'b0;
    endtask

    task automatic take_beat();
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0;
        bus.r_ready = 0;
        bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
        bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0;
        bus.b_ready = 0;

        // Reset state
        tick(); tick();
        check("rst_ar_ready", 32'(bus.ar_ready), 32'd0);
        check("rst_aw_ready", 32'(bus.aw_ready), 32'd0);
        check("rst_w_ready", 32'(bus.w_ready), 32'd0);
        check("rst_r_valid", 32'(bus.r_valid), 32'd0);
        check("rst_b_valid", 32'(bus.b_valid), 32'd0);
        check("rst_r_data", bus.r_data, 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_ar_ready", 32'(bus.ar_ready), 32'd1);
        check("idle_w_ready", 32'(bus.w_ready), 32'd0);

        // Single write then read back
        wr_burst(32'h8000_0000, 4'd1, 8'd0, AXI_BURST_INCR, 32'hDEAD_BEEF, 4'hF, 0, resp, bid);
        check("wr0_bresp", 32'(resp), 32'(AXI_RESP_OKAY));
        check("wr0_bid", 32'(bid), 32'd1);
        rd_start(32'h8000_0000, 4'd6, 8'd0, AXI_BURST_INCR);
        check("rd0_ar_low", 32'(bus.ar_ready), 32'd0);
        check("rd0_rvalid_early", 32'(bus.r_valid), 32'd0);
        tick();
        check("rd0_rvalid", 32'(bus.r_valid), 32'd1);
        check("rd0_data", bus.r_data, 32'hDEAD_BEEF);
        check("rd0_last", 32'(bus.r_last), 32'd1);
        check("rd0_resp", 32'(bus.r_resp), 32'(AXI_RESP_OKAY));
        check("rd0_rid", 32'(bus.r_id), 32'd6);
        take_beat();
        check("rd0_done", 32'(bus.r_valid), 32'd0);

        // INCR write of words 4..7, then stalled INCR read
        wr_burst(32'h8000_0010, 4'd2, 8'd3, AXI_BURST_INCR, 32'hC0DE_0004, 4'hF, 3, resp, bid);
        check("wr4_bresp", 32'(resp), 32'(AXI_RESP_OKAY));
        exp_beats[0] = 32'hC0DE_0004; exp_beats[1] = 32'hC0DE_0005;
        exp_beats[2] = 32'hC0DE_0006; exp_beats[3] = 32'hC0DE_0007;
        rd_start(32'h8000_0010, 4'd7, 8'd3, AXI_BURST_INCR);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", 32'(bus.r_valid), 32'd1);
            check("stall_data", bus.r_data, exp_beats[i]);
            check("stall_last", 32'(bus.r_last), 32'(i == 3));
            bus.r_ready = 1'b1;
            tick();
            bus.r_ready = 1'b0;
            if (i < 3) begin
                check("nobubble_data", bus.r_data, exp_beats[i+1]);
                tick();
                check("held_data", bus.r_data, exp_beats[i+1]);
                check("held_last", 32'(bus.r_last), 32'(i + 1 == 3));
            end
        end
        check("stall_end", 32'(bus.r_valid), 32'd0);

        // FIXED read repeats the start word
        rd_start(32'h8000_0014, 4'd1, 8'd1, AXI_BURST_FIXED);
        tick();
        check("fix_b0", bus.r_data, 32'hC0DE_0005);
        check("fix_l0", 32'(bus.r_last), 32'd0);
        take_beat();
        check("fix_b1", bus.r_data, 32'hC0DE_0005);
        check("fix_l1", 32'(bus.r_last), 32'd1);
        take_beat();

        // Byte strobes
        wr_burst(32'h8000_0040, 4'd0, 8'd0, AXI_BURST_INCR, 32'h1122_3344, 4'hF, 0, resp, bid);
        wr_burst(32'h8000_0040, 4'd0, 8'd0, AXI_BURST_INCR, 32'hAAAA_5555, 4'b0011, 0, resp, bid);
        check("strb_bresp", 32'(resp), 32'(AXI_RESP_OKAY));
        rd_start(32'h8000_0040, 4'd0, 8'd0, AXI_BURST_INCR);
        tick();
        check("strb_data", bus.r_data, 32'h1122_5555);
        take_beat();

        // Out-of-range read and WRAP write
        rd_start(32'h7FFF_FFFC, 4'd2, 8'd0, AXI_BURST_INCR);
        tick();
        check("oor_valid", 32'(bus.r_valid), 32'd1);
        check("oor_resp", 32'(bus.r_resp), 32'(AXI_RESP_SLVERR));
        check("oor_data", bus.r_data, 32'h0);
        check("oor_last", 32'(bus.r_last), 32'd1);
        take_beat();
        wr_burst(32'h8000_0080, 4'd0, 8'd0, AXI_BURST_INCR, 32'h5A5A_5A5A, 4'hF, 0, resp, bid);
        wr_burst(32'h8000_0080, 4'd4, 8'd1, AXI_BURST_WRAP, 32'hFFFF_FFFF, 4'hF, 1, resp, bid);
        check("wrap_bresp", 32'(resp), 32'(AXI_RESP_SLVERR));
        check("wrap_bid", 32'(bid), 32'd4);
        rd_start(32'h8000_0080, 4'd0, 8'd0, AXI_BURST_INCR);
        tick();
        check("wrap_unchanged", bus.r_data, 32'h5A5A_5A5A);
        take_beat();

        // Early w_last on the first of two beats
        wr_burst(32'h8000_00C0, 4'd3, 8'd1, AXI_BURST_INCR, 32'h0000_1000, 4'hF, 0, resp, bid);
        check("early_bresp", 32'(resp), 32'(AXI_RESP_SLVERR));
        check("early_bid", 32'(bid), 32'd3);

        // Reset in the middle of an 8-beat read
        rd_start(32'h8000_0010, 4'd5, 8'd7, AXI_BURST_INCR);
        tick();
        take_beat();
        check("mid_valid", 32'(bus.r_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(bus.r_valid), 32'd0);
        check("mid_rst_last", 32'(bus.r_last), 32'd0);
        check("mid_rst_data", bus.r_data, 32'h0);
        check("mid_rst_ar", 32'(bus.ar_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ar", 32'(bus.ar_ready), 32'd1);
        rd_start(32'h8000_0000, 4'd9, 8'd0, AXI_BURST_INCR);
        tick();
        check("post_rst_data", bus.r_data, 32'hDEAD_BEEF);
        check("post_rst_rid", 32'(bus.r_id), 32'd9);
        check("post_rst_last", 32'(bus.r_last), 32'd1);
        take_beat();
        check("post_rst_done", 32'(bus.r_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
